proc_sequencer: RTL and testbench
=================================

# proc_sequencer

Control sequencer for the 16-bit simple processor datapath (register bank R0–R7, A/G registers around the ALU, shared bus multiplexer). It captures a 9-bit instruction word from the input bus when `run` is raised. It then steps through up to four timesteps (T0–T3), driving register-load enables, the bus-mux select and the ALU opcode, and pulses `done` when the instruction completes. It sits between the instruction source and the datapath and replaces the free-running step counter as the only sequencing authority.

## Interface
Parameters:
- `DIN_W`, 16, width of the input data bus `din`.
- `IR_LSB`, 7, bit position of the instruction-word LSB within `din`. The instruction word is `din[IR_LSB+8:IR_LSB]`.

Ports:
- `clock`  in  1  single clock; all state changes on rising edge.
- `resetn`  in  1  synchronous, **active-high** reset (name kept for consistency with the rest of the processor; asserting it high resets).
- `run`  in  1  start request, sampled only in T0.
- `din`  in  DIN_W  input data bus; the instruction is taken from it.
- `ir_in`  out  1  IR-capture strobe to the datapath (mirrors internal capture).
- `reg_in`  out  8  one-hot load enable for R0..R7.
- `bus_sel`  out  4  bus-mux select: 0–7 = R0..R7, 8 = G, 9 = DIN; 15 = idle (bus undriven/zero).
- `a_in`  out  1  load A from bus.
- `g_in`  out  1  load G from ALU.
- `alu_op`  out  3  ALU function (equals opcode in ALU instructions, else 0).
- `done`  out  1  one-cycle completion pulse.
- `illegal`  out  1  one-cycle pulse, coincident with `done`, for opcode 111.
- `busy`  out  1  high in T1–T3.

## Operation
- Instruction word `III XXX YYY`: opcode I, destination/first operand Rx, source Ry.
- Opcodes:
  - 000 mv: Rx ← Ry.
  - 001 mvi: Rx ← DIN.
  - 010 add, 011 sub, 100 and, 101 or, 110 xor: Rx ← Rx op Ry.
  - 111 illegal.
- State machine with states T0, T1, T2, T3. The instruction register `ir` (9 bits) is internal.
- T0 (idle):
  - `ir_in` = `run`.
  - If `run`=1: `ir` ← instruction word, next state T1.
  - If `run`=0: stay in T0; `ir` unchanged.
  - All other outputs are 0 (`bus_sel`=15).
- T1:
  - mv: `bus_sel`=Ry, `reg_in`[Rx]=1, `done`=1, next T0.
  - mvi: `bus_sel`=9, `reg_in`[Rx]=1, `done`=1, next T0.
  - ALU op: `bus_sel`=Rx, `a_in`=1, next T2.
  - Illegal: `done`=`illegal`=1, no enables asserted, next T0.
- T2 (ALU only): `bus_sel`=Ry, `g_in`=1, `alu_op`=opcode, next T3.
- T3 (ALU only): `bus_sel`=8, `reg_in`[Rx]=1, `done`=1, next T0.
- Outputs are Moore-decoded from (state, `ir`) only. They must not depend combinationally on `run` except `ir_in` in T0.
- `run` is ignored in T1–T3. A `run` held high continuously starts a new instruction in every T0 visit.
- Rx = Ry is legal; for example `add R3,R3` gives R3 ← 2·R3.

## Timing
- Reset (`resetn`=1 at an edge): state ← T0, `ir` ← 0.
  - Outputs during and after reset: all 0, `bus_sel`=15, `busy`=0.
  - Reset mid-instruction aborts it: no `done`, and no further enables after the reset edge.
- Reset has priority over `run` in the same cycle.
- Latency from the `run` sample edge to the `done` cycle:
  - mv, mvi, illegal: 1 cycle.
  - ALU ops: 3 cycles.
- Throughput: one T0 cycle separates instructions. mv/mvi therefore sustain 2 cycles per instruction and ALU ops 4.
- `done` is never high for two consecutive cycles.
- `reg_in` is zero or one-hot in every cycle.
- Undefined encodings are unreachable; if a bit fault reaches one, the FSM returns to T0.

## Structure
- Shared package `proc_pkg` holds:
  - opcode constants (`OP_MV`…`OP_ILL`);
  - `bus_sel` codes (`SEL_G`=8, `SEL_DIN`=9, `SEL_NONE`=15);
  - the state enum (T0–T3);
  - ALU op encodings, shared with the ALU.
- One sub-module is natural: `dec3to8`, a 3→8 one-hot decoder with enable, used to generate `reg_in` from Rx.

## Test plan
- Reset, then check: all outputs 0, `bus_sel`=15, `busy`=0. Hold `run`=0 for 5 cycles; state stays T0.
- `din`[15:7]=001_010_000 (mvi R2), `run`=1 → next cycle `bus_sel`=9, `reg_in`=0000_0100, `done`=1, then T0.
- 000_101_011 (mv R5,R3) → T1: `bus_sel`=3, `reg_in`=0010_0000, `done`=1.
- 011_001_110 (sub R1,R6):
  - T1: `bus_sel`=1, `a_in`=1.
  - T2: `bus_sel`=6, `g_in`=1, `alu_op`=011.
  - T3: `bus_sel`=8, `reg_in`=0000_0010, `done`=1.
  - `run` toggled during T1–T3 has no effect.
- 111_xxx_xxx → T1: `done`=`illegal`=1, `reg_in`=0, `a_in`=`g_in`=0.
- Start add R0,R7, assert `resetn` in T2 → next cycle T0, all outputs 0, no `done` observed. Back-to-back mv with `run` held high yields a `done` every 2 cycles.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor: opcodes, bus-mux codes,
// sequencer states, ALU encodings and the sequencer's control decode.
package proc_pkg;

  localparam int unsigned IR_W  = 9;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned NREG  = 8;

  localparam logic [OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;
  localparam logic [OP_W-1:0] OP_AND = 3'b100;
  localparam logic [OP_W-1:0] OP_OR  = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR = 3'b110;
  localparam logic [OP_W-1:0] OP_ILL = 3'b111;

  // ALU function codes; chosen equal to the opcodes so the sequencer can pass them through.
  localparam logic [OP_W-1:0] ALU_NOP = 3'b000;
  localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;
  localparam logic [OP_W-1:0] ALU_SUB = OP_SUB;
  localparam logic [OP_W-1:0] ALU_AND = OP_AND;
  localparam logic [OP_W-1:0] ALU_OR  = OP_OR;
  localparam logic [OP_W-1:0] ALU_XOR = OP_XOR;

  localparam logic [SEL_W-1:0] SEL_G    = 4'd8;
  localparam logic [SEL_W-1:0] SEL_DIN  = 4'd9;
  localparam logic [SEL_W-1:0] SEL_NONE = 4'd15;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_e;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [2:0]      rx;
    logic [2:0]      ry;
  } instr_t;

  typedef struct packed {
    logic [SEL_W-1:0] bus_sel;
    logic             reg_en;
    logic             a_in;
    logic             g_in;
    logic [OP_W-1:0]  alu_op;
    logic             done;
    logic             illegal;
    logic             busy;
  } ctrl_t;

  function automatic logic is_alu(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  // Moore control decode from (state, instruction); reg_en is expanded to one-hot by dec3to8.
  function automatic ctrl_t decode(input state_e st, input instr_t ir);
    ctrl_t c;
    c         = '0;
    c.bus_sel = SEL_NONE;
    c.alu_op  = ALU_NOP;
    case (st)
      T1: begin
        c.busy = 1'b1;
        case (ir.op)
          OP_MV: begin
            c.bus_sel = SEL_W'(ir.ry);
            c.reg_en  = 1'b1;
            c.done    = 1'b1;
          end
          OP_MVI: begin
            c.bus_sel = SEL_DIN;
            c.reg_en  = 1'b1;
            c.done    = 1'b1;
          end
          OP_ILL: begin
            c.done    = 1'b1;
            c.illegal = 1'b1;
          end
          default: begin
            c.bus_sel = SEL_W'(ir.rx);
            c.a_in    = 1'b1;
          end
        endcase
      end
      T2: begin
        c.busy    = 1'b1;
        c.bus_sel = SEL_W'(ir.ry);
        c.g_in    = 1'b1;
        c.alu_op  = ir.op;
      end
      T3: begin
        c.busy    = 1'b1;
        c.bus_sel = SEL_G;
        c.reg_en  = 1'b1;
        c.done    = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable.
//   sel_i    : index to decode
//   en_i     : when low the output is all zeros
//   onehot_o : one-hot (or zero) result
module dec3to8 (
  input  logic [2:0] sel_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);

  assign onehot_o = en_i ? (8'b1 << sel_i) : 8'b0;

endmodule

// File: rtl/proc_sequencer.sv
// Control sequencer for the 16-bit simple processor datapath.
// Captures a 9-bit instruction from din on run (in T0) and steps T1..T3,
// driving register loads, the bus-mux select and the ALU opcode.
//   clock, resetn : clock and synchronous active-high reset
//   run, din      : start request and input bus carrying the instruction
//   ir_in         : instruction-capture strobe (combinational, T0 only)
//   reg_in        : one-hot R0..R7 load enables
//   bus_sel       : bus-mux select (0-7 Rn, 8 G, 9 DIN, 15 idle)
//   a_in, g_in    : A / G load enables
//   alu_op        : ALU function
//   done, illegal : completion pulse and illegal-opcode pulse
//   busy          : high in T1..T3
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned DIN_W  = 16,
  parameter int unsigned IR_LSB = 7
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             run,
  input  logic [DIN_W-1:0] din,
  output logic             ir_in,
  output logic [NREG-1:0]  reg_in,
  output logic [SEL_W-1:0] bus_sel,
  output logic             a_in,
  output logic             g_in,
  output logic [OP_W-1:0]  alu_op,
  output logic             done,
  output logic             illegal,
  output logic             busy
);

  state_e          state_q, state_d;
  instr_t          ir_q, ir_d;
  ctrl_t           ctrl_d;
  logic [NREG-1:0] reg_in_d;
  logic            unused_din;

  // Only the instruction field of din is consumed here.
  assign unused_din = ^din;

  // Next state and instruction capture; run matters only in T0.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      T0: begin
        if (run) begin
          ir_d    = instr_t'(din[IR_LSB +: IR_W]);
          state_d = T1;
        end
      end
      T1:      state_d = is_alu(ir_q.op) ? T2 : T0;
      T2:      state_d = T3;
      T3:      state_d = T0;
      default: state_d = T0;
    endcase
  end

  // Outputs for the upcoming state are decoded ahead and registered.
  assign ctrl_d = decode(state_d, ir_d);

  dec3to8 u_dec (
    .sel_i    (ir_d.rx),
    .en_i     (ctrl_d.reg_en),
    .onehot_o (reg_in_d)
  );

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q <= T0;
      ir_q    <= '0;
      reg_in  <= '0;
      bus_sel <= SEL_NONE;
      a_in    <= 1'b0;
      g_in    <= 1'b0;
      alu_op  <= ALU_NOP;
      done    <= 1'b0;
      illegal <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      reg_in  <= reg_in_d;
      bus_sel <= ctrl_d.bus_sel;
      a_in    <= ctrl_d.a_in;
      g_in    <= ctrl_d.g_in;
      alu_op  <= ctrl_d.alu_op;
      done    <= ctrl_d.done;
      illegal <= ctrl_d.illegal;
      busy    <= ctrl_d.busy;
    end
  end

  // Capture strobe follows run in T0; a reset in the same cycle wins.
  assign ir_in = (state_q == T0) && run && !resetn;

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_proc_sequencer;

  logic        clock;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        ir_in;
  logic [7:0]  reg_in;
  logic [3:0]  bus_sel;
  logic        a_in;
  logic        g_in;
  logic [2:0]  alu_op;
  logic        done;
  logic        illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;

  proc_sequencer #(.DIN_W(16), .IR_LSB(7)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .run     (run),
    .din     (din),
    .ir_in   (ir_in),
    .reg_in  (reg_in),
    .bus_sel (bus_sel),
    .a_in    (a_in),
    .g_in    (g_in),
    .alu_op  (alu_op),
    .done    (done),
    .illegal (illegal),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       ir_in;
    logic [7:0] reg_in;
    logic [3:0] bus_sel;
    logic       a_in;
    logic       g_in;
    logic [2:0] alu_op;
    logic       done;
    logic       illegal;
    logic       busy;
  } out_t;

  typedef struct packed {
    logic        run;
    logic [15:0] din;
    logic        rst;
    out_t        exp;
  } vec_t;

  function automatic out_t mk(input logic iri, input logic [7:0] r, input logic [3:0] s,
                              input logic a, input logic g, input logic [2:0] op,
                              input logic d, input logic il, input logic b);
    out_t o;
    o = '{iri, r, s, a, g, op, d, il, b};
    return o;
  endfunction

  function automatic out_t idle(input logic iri);
    return mk(iri, 8'h00, 4'd15, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Reference model: each accepted instruction becomes a list of the cycles it will show.
  out_t exp_q[$];

  function automatic out_t model_cur(input logic r, input logic rst);
    if (exp_q.size() > 0) return exp_q[0];
    return idle(r & ~rst);
  endfunction

  task automatic model_step(input logic r, input logic [15:0] d, input logic rst);
    logic [8:0] iw;
    logic [2:0] op, rx, ry;
    logic [7:0] oh;
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end else if (r) begin
      iw = d[15:7];
      op = iw[8:6];
      rx = iw[5:3];
      ry = iw[2:0];
      oh = 8'(1 << rx);
      case (op)
        3'd0: exp_q.push_back(mk(1'b0, oh, {1'b0, ry}, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1));
        3'd1: exp_q.push_back(mk(1'b0, oh, 4'd9, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1));
        3'd7: exp_q.push_back(mk(1'b0, 8'h00, 4'd15, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1));
        default: begin
          exp_q.push_back(mk(1'b0, 8'h00, {1'b0, rx}, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
          exp_q.push_back(mk(1'b0, 8'h00, {1'b0, ry}, 1'b0, 1'b1, op, 1'b0, 1'b0, 1'b1));
          exp_q.push_back(mk(1'b0, oh, 4'd8, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1));
        end
      endcase
    end
  endtask

  // One clock cycle: drive after the falling edge, sample, then advance the model on the rising edge.
  task automatic cyc(input logic r, input logic [15:0] d, input logic rst,
                     output out_t got, output out_t mexp);
    @(negedge clock);
    run = r; din = d; resetn = rst;
    #1;
    got  = '{ir_in, reg_in, bus_sel, a_in, g_in, alu_op, done, illegal, busy};
    mexp = model_cur(r, rst);
    @(posedge clock);
    model_step(r, d, rst);
  endtask

  task automatic chk(input string name, input out_t g, input out_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, g, e);
    end
  endtask

  vec_t tbl[$];
  out_t got, mexp;
  logic prev_done;
  int   ndone;

  task automatic add(input logic r, input logic [15:0] d, input logic rst, input out_t e);
    vec_t v;
    v = '{r, d, rst, e};
    tbl.push_back(v);
  endtask

  initial begin
    run = 1'b0; din = 16'h0000; resetn = 1'b1;
    repeat (2) @(posedge clock);

    // Reset state, idle hold, then mvi / mv / sub / illegal / reset abort.
    for (int i = 0; i < 5; i++) add(1'b0, 16'h0000, 1'b0, idle(1'b0));
    add(1'b1, 16'h2800, 1'b0, idle(1'b1));
    add(1'b0, 16'h0000, 1'b0, mk(1'b0, 8'h04, 4'd9, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1));
    add(1'b0, 16'h0000, 1'b0, idle(1'b0));
    add(1'b1, 16'h1580, 1'b0, idle(1'b1));
    add(1'b0, 16'h0000, 1'b0, mk(1'b0, 8'h20, 4'd3, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1));
    add(1'b1, 16'h6700, 1'b0, idle(1'b1));
    add(1'b1, 16'h0000, 1'b0, mk(1'b0, 8'h00, 4'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
    add(1'b0, 16'h1580, 1'b0, mk(1'b0, 8'h00, 4'd6, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1));
    add(1'b1, 16'h1580, 1'b0, mk(1'b0, 8'h02, 4'd8, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1));
    add(1'b0, 16'h0000, 1'b0, idle(1'b0));
    add(1'b1, 16'hE000, 1'b0, idle(1'b1));
    add(1'b0, 16'h0000, 1'b0, mk(1'b0, 8'h00, 4'd15, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1));
    add(1'b1, 16'h4380, 1'b0, idle(1'b1));
    add(1'b0, 16'h0000, 1'b0, mk(1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
    add(1'b0, 16'h0000, 1'b1, mk(1'b0, 8'h00, 4'd7, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1));
    add(1'b0, 16'h0000, 1'b0, idle(1'b0));
    add(1'b1, 16'h1580, 1'b1, idle(1'b0));
    add(1'b0, 16'h0000, 1'b0, idle(1'b0));
    add(1'b0, 16'h0000, 1'b0, idle(1'b0));

    foreach (tbl[i]) begin
      cyc(tbl[i].run, tbl[i].din, tbl[i].rst, got, mexp);
      chk($sformatf("vec%0d", i), got, tbl[i].exp);
    end

    // Back-to-back mv with run held high: a done every other cycle.
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 16'({3'b000, 6'($urandom)} << 7) | 16'($urandom_range(0, 127)), 1'b0, got, mexp);
      chk("b2b_mv", got, mexp);
      if (got.done) ndone++;
    end
    checks++;
    if (ndone != 10) begin
      errors++;
      $display("FAIL b2b_done_count got=%0d exp=%0d", ndone, 10);
    end

    // Back-to-back ALU ops: a done every fourth cycle.
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 16'({3'($urandom_range(2, 6)), 6'($urandom)} << 7), 1'b0, got, mexp);
      chk("b2b_alu", got, mexp);
      if (got.done) ndone++;
    end
    checks++;
    if (ndone != 5) begin
      errors++;
      $display("FAIL b2b_alu_done_count got=%0d exp=%0d", ndone, 5);
    end

    // Randomized traffic including occasional resets.
    prev_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 39) == 0), got, mexp);
      chk("rand", got, mexp);
      checks++;
      if (!$onehot0(got.reg_in)) begin
        errors++;
        $display("FAIL reg_in_onehot got=%b exp=onehot0", got.reg_in);
      end
      if (got.done) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_twice got=1 exp=0");
        end
      end
      prev_done = got.done;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
